// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, NOP word and the execute-stage
// result types, plus the ALU and branch-compare helpers used by ex_alu.
package riscv_pkg;

   localparam logic [6:0] R_type       = 7'b0110011;
   localparam logic [6:0] I_type_alu   = 7'b0010011;
   localparam logic [6:0] I_type_ld    = 7'b0000011;
   localparam logic [6:0] S_type       = 7'b0100011;
   localparam logic [6:0] B_type       = 7'b1100011;
   localparam logic [6:0] J_jal        = 7'b1101111;
   localparam logic [6:0] I_jalr       = 7'b1100111;
   localparam logic [6:0] U_type_lui   = 7'b0110111;
   localparam logic [6:0] U_type_auipc = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] target;
      logic        taken;
   } ex_res_t;

   typedef struct packed {
      logic [31:0] aluresult;
      logic [31:0] branch_pc;
      logic        taken;
      logic [31:0] pc;
      logic [31:0] instruction;
      logic [31:0] op2;
   } ex_regs_t;

   localparam ex_regs_t EX_REGS_RESET = '{
      aluresult: '0, branch_pc: '0, taken: 1'b0, pc: '0, instruction: NOP, op2: '0
   };

   // alt selects SUB for funct3=000 and arithmetic right shift for funct3=101.
   function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [4:0] shamt;
      shamt = b[4:0];
      case (f3)
         F3_ADD:  alu_calc = alt ? a - b : a + b;
         F3_SLL:  alu_calc = a << shamt;
         F3_SLT:  alu_calc = {31'b0, $signed(a) < $signed(b)};
         F3_SLTU: alu_calc = {31'b0, a < b};
         F3_XOR:  alu_calc = a ^ b;
         F3_SR:   alu_calc = alt ? 32'($signed(a) >>> shamt) : a >> shamt;
         F3_OR:   alu_calc = a | b;
         default: alu_calc = a & b;
      endcase
   endfunction

   function automatic logic branch_cmp(input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
      case (f3)
         F3_BEQ:  branch_cmp = (a == b);
         F3_BNE:  branch_cmp = (a != b);
         F3_BLT:  branch_cmp = ($signed(a) < $signed(b));
         F3_BGE:  branch_cmp = ($signed(a) >= $signed(b));
         F3_BLTU: branch_cmp = (a < b);
         F3_BGEU: branch_cmp = (a >= b);
         default: branch_cmp = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Operand-fetch to execute bus: control, incoming operands and registered results.
interface ex_stage_if;
   logic        stall;
   logic        flush;
   logic [31:0] of_pc;
   logic [31:0] of_instruction;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] of_immx;
   logic [31:0] ex_aluresult;
   logic [31:0] ex_branch_pc;
   logic        ex_is_branch_taken;
   logic [31:0] ex_pc;
   logic [31:0] ex_instruction;
   logic [31:0] ex_op2;

   modport master (
      output stall, flush, of_pc, of_instruction, op1, op2, of_immx,
      input  ex_aluresult, ex_branch_pc, ex_is_branch_taken, ex_pc, ex_instruction, ex_op2
   );

   modport slave (
      input  stall, flush, of_pc, of_instruction, op1, op2, of_immx,
      output ex_aluresult, ex_branch_pc, ex_is_branch_taken, ex_pc, ex_instruction, ex_op2
   );
endinterface

// File: rtl/ex_alu.sv
// Combinational RV32I execute datapath: ALU, address/link generation and branch
// comparator, producing the result, next-PC target and taken flag.
module ex_alu
   import riscv_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic [31:0] imm_i,
   output ex_res_t     res_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        bit30;
   logic [31:0] pc_plus4;
   logic [31:0] pc_imm;
   logic [31:0] op1_imm;
   logic        cmp;

   assign opcode   = instr_i[6:0];
   assign funct3   = instr_i[14:12];
   assign bit30    = instr_i[30];
   assign pc_plus4 = pc_i + 32'd4;
   assign pc_imm   = pc_i + imm_i;
   assign op1_imm  = op1_i + imm_i;
   assign cmp      = branch_cmp(funct3, op1_i, op2_i);

   always_comb begin
      // NOTE: every field gets a default first so no path through the case infers a latch.
      res_o.result = '0;
      res_o.target = pc_plus4;
      res_o.taken  = 1'b0;
      case (opcode)
         R_type:     res_o.result = alu_calc(funct3, bit30, op1_i, op2_i);
         // Immediate forms have no SUB; bit 30 only matters for SRAI.
         I_type_alu: res_o.result = alu_calc(funct3, bit30 && (funct3 == F3_SR), op1_i, imm_i);
         I_type_ld,
         S_type:     res_o.result = op1_imm;
         B_type: begin
            res_o.taken  = cmp;
            res_o.target = cmp ? pc_imm : pc_plus4;
         end
         J_jal: begin
            res_o.result = pc_plus4;
            res_o.target = pc_imm;
            res_o.taken  = 1'b1;
         end
         I_jalr: begin
            res_o.result = pc_plus4;
            res_o.target = {op1_imm[31:1], 1'b0};
            res_o.taken  = 1'b1;
         end
         U_type_lui:   res_o.result = imm_i;
         U_type_auipc: res_o.result = pc_imm;
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: registers the ex_alu results for memory
// access, with reset > flush > stall > capture priority.
module ex_stage
   import riscv_pkg::*;
(
   input  logic        clk1,
   input  logic        rst,
   ex_stage_if.slave   bus
);

   ex_res_t  alu_res;
   ex_regs_t regs_d;
   ex_regs_t regs_q;

   ex_alu u_ex_alu (
      .pc_i    (bus.of_pc),
      .instr_i (bus.of_instruction),
      .op1_i   (bus.op1),
      .op2_i   (bus.op2),
      .imm_i   (bus.of_immx),
      .res_o   (alu_res)
   );

   always_comb begin
      regs_d = regs_q;
      if (bus.flush) begin
         // Squashed slot keeps its PC but can never redirect fetch.
         regs_d             = EX_REGS_RESET;
         regs_d.pc          = bus.of_pc;
      end else if (!bus.stall) begin
         regs_d.aluresult   = alu_res.result;
         regs_d.branch_pc   = alu_res.target;
         regs_d.taken       = alu_res.taken;
         regs_d.pc          = bus.of_pc;
         regs_d.instruction = bus.of_instruction;
         regs_d.op2         = bus.op2;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all registers update together.
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) regs_q <= EX_REGS_RESET;
      else      regs_q <= regs_d;
   end

   assign bus.ex_aluresult       = regs_q.aluresult;
   assign bus.ex_branch_pc       = regs_q.branch_pc;
   assign bus.ex_is_branch_taken = regs_q.taken;
   assign bus.ex_pc              = regs_q.pc;
   assign bus.ex_instruction     = regs_q.instruction;
   assign bus.ex_op2             = regs_q.op2;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table plus hand-written
// reset, flush, stall and back-to-back branch sequences.
module tb_ex_stage;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
      logic [31:0] exp_res;
      logic [31:0] exp_tgt;
      logic        exp_taken;
   } vec_t;

   logic clk1 = 1'b0;
   logic rst  = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[$];

   ex_stage_if bus ();

   ex_stage dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk1 = ~clk1;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   function automatic logic [31:0] enc(input logic b30, input logic [2:0] f3, input logic [6:0] op);
      return {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, op};
   endfunction

   function automatic vec_t mk(input string n, input logic [31:0] instr, pc, op1, op2, imm,
                               input logic [31:0] res, tgt, input logic taken);
      vec_t v;
      v.name = n; v.instr = instr; v.pc = pc; v.op1 = op1; v.op2 = op2; v.imm = imm;
      v.exp_res = res; v.exp_tgt = tgt; v.exp_taken = taken;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] res, tgt, input logic taken,
                            input logic [31:0] pc, instr, op2);
      check({tag, ".result"}, bus.ex_aluresult, res);
      check({tag, ".target"}, bus.ex_branch_pc, tgt);
      check({tag, ".taken"},  {31'b0, bus.ex_is_branch_taken}, {31'b0, taken});
      check({tag, ".pc"},     bus.ex_pc, pc);
      check({tag, ".instr"},  bus.ex_instruction, instr);
      check({tag, ".op2"},    bus.ex_op2, op2);
   endtask

   task automatic drive(input logic [31:0] instr, pc, op1, op2, imm);
      bus.of_instruction = instr;
      bus.of_pc          = pc;
      bus.op1            = op1;
      bus.op2            = op2;
      bus.of_immx        = imm;
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(enc(1'b0, 3'b000, 7'b0110011), 32'h0000_0010, 32'd5, 32'd7, 32'h0000_0FFF);

      // Reset held across several edges with nonzero inputs.
      repeat (3) step();
      check_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, NOP_W, 32'h0);
      @(negedge clk1);
      rst = 1'b1;
      #1;
      check_all("reset_release", 32'h0, 32'h0, 1'b0, 32'h0, NOP_W, 32'h0);
      step();
      check_all("first_capture", 32'd12, 32'h14, 1'b0, 32'h10, enc(1'b0, 3'b000, 7'b0110011), 32'd7);

      vecs.push_back(mk("sub",   enc(1, 3'b000, 7'b0110011), 32'h100, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 32'h104, 0));
      vecs.push_back(mk("add",   enc(0, 3'b000, 7'b0110011), 32'h100, 32'd5, 32'd7, 0, 32'h0000_000C, 32'h104, 0));
      vecs.push_back(mk("sra",   enc(1, 3'b101, 7'b0110011), 32'h100, 32'h8000_0000, 32'd4, 0, 32'hF800_0000, 32'h104, 0));
      vecs.push_back(mk("srl",   enc(0, 3'b101, 7'b0110011), 32'h100, 32'h8000_0000, 32'd4, 0, 32'h0800_0000, 32'h104, 0));
      vecs.push_back(mk("slt",   enc(0, 3'b010, 7'b0110011), 32'h100, 32'hFFFF_FFFF, 32'd1, 0, 32'h1, 32'h104, 0));
      vecs.push_back(mk("sltu",  enc(0, 3'b011, 7'b0110011), 32'h100, 32'hFFFF_FFFF, 32'd1, 0, 32'h0, 32'h104, 0));
      vecs.push_back(mk("sll",   enc(0, 3'b001, 7'b0110011), 32'h100, 32'd1, 32'h25, 0, 32'h20, 32'h104, 0));
      vecs.push_back(mk("xor",   enc(0, 3'b100, 7'b0110011), 32'h100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0, 32'h104, 0));
      vecs.push_back(mk("or",    enc(0, 3'b110, 7'b0110011), 32'h100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hFFF0_FFF0, 32'h104, 0));
      vecs.push_back(mk("and",   enc(0, 3'b111, 7'b0110011), 32'h100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000, 32'h104, 0));
      vecs.push_back(mk("addi_neg", enc(1, 3'b000, 7'b0010011), 32'h100, 32'd5, 32'h99, 32'hFFFF_FFFF, 32'd4, 32'h104, 0));
      vecs.push_back(mk("srai",  enc(1, 3'b101, 7'b0010011), 32'h100, 32'h8000_0000, 32'h0, 32'h404, 32'hF800_0000, 32'h104, 0));
      vecs.push_back(mk("srli",  enc(0, 3'b101, 7'b0010011), 32'h100, 32'h8000_0000, 32'h0, 32'h4, 32'h0800_0000, 32'h104, 0));
      vecs.push_back(mk("load",  enc(0, 3'b010, 7'b0000011), 32'h100, 32'h1000, 32'h0, 32'hFFFF_FFFC, 32'h0FFC, 32'h104, 0));
      vecs.push_back(mk("store", enc(0, 3'b010, 7'b0100011), 32'h100, 32'h2000, 32'hCAFE, 32'h8, 32'h2008, 32'h104, 0));
      vecs.push_back(mk("blt",   enc(0, 3'b100, 7'b1100011), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0, 32'h120, 1));
      vecs.push_back(mk("bltu",  enc(0, 3'b110, 7'b1100011), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0, 32'h104, 0));
      vecs.push_back(mk("beq",   enc(0, 3'b000, 7'b1100011), 32'h100, 32'd3, 32'd3, 32'h20, 32'h0, 32'h120, 1));
      vecs.push_back(mk("bne",   enc(0, 3'b001, 7'b1100011), 32'h100, 32'd3, 32'd3, 32'h20, 32'h0, 32'h104, 0));
      vecs.push_back(mk("bge",   enc(0, 3'b101, 7'b1100011), 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h0, 32'h120, 1));
      vecs.push_back(mk("bgeu",  enc(0, 3'b111, 7'b1100011), 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h0, 32'h104, 0));
      vecs.push_back(mk("jal",   enc(1, 3'b000, 7'b1101111), 32'h200, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h204, 32'h1F0, 1));
      vecs.push_back(mk("jalr",  enc(0, 3'b000, 7'b1100111), 32'h40, 32'h1001, 32'h0, 32'h4, 32'h44, 32'h1004, 1));
      vecs.push_back(mk("jalr_odd", enc(0, 3'b000, 7'b1100111), 32'h80, 32'h10, 32'h0, 32'h3, 32'h84, 32'h12, 1));
      vecs.push_back(mk("lui",   enc(0, 3'b101, 7'b0110111), 32'h100, 32'h77, 32'h0, 32'h1234_5000, 32'h1234_5000, 32'h104, 0));
      vecs.push_back(mk("auipc_wrap", enc(0, 3'b000, 7'b0010111), 32'h1000, 32'h0, 32'h0, 32'hFFFF_F000, 32'h0, 32'h1004, 0));
      vecs.push_back(mk("bad_opcode", enc(0, 3'b000, 7'b1111111), 32'h100, 32'd5, 32'd7, 32'h20, 32'h0, 32'h104, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].instr, vecs[i].pc, vecs[i].op1, vecs[i].op2, vecs[i].imm);
         step();
         check_all(vecs[i].name, vecs[i].exp_res, vecs[i].exp_tgt, vecs[i].exp_taken,
                   vecs[i].pc, vecs[i].instr, vecs[i].op2);
      end

      // Flush over a taken BEQ: NOP captured, PC kept, nothing redirects.
      bus.flush = 1'b1;
      drive(enc(0, 3'b000, 7'b1100011), 32'hA00, 32'd9, 32'h77, 32'h40);
      step();
      check_all("flush_beq", 32'h0, 32'h0, 1'b0, 32'hA00, NOP_W, 32'h0);
      bus.flush = 1'b0;

      // Stall: LUI captured, then held for three cycles under changing inputs.
      drive(enc(0, 3'b000, 7'b0110111), 32'h300, 32'h0, 32'h55, 32'h1234_5000);
      step();
      check_all("stall_lui", 32'h1234_5000, 32'h304, 1'b0, 32'h300, enc(0, 3'b000, 7'b0110111), 32'h55);
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(enc(0, 3'b000, 7'b0110011), 32'h400 + 32'(k), 32'(k), 32'(k + 1), 32'h0);
         step();
         check_all($sformatf("stall_hold%0d", k), 32'h1234_5000, 32'h304, 1'b0, 32'h300,
                   enc(0, 3'b000, 7'b0110111), 32'h55);
      end
      bus.stall = 1'b0;
      drive(enc(0, 3'b000, 7'b0110011), 32'h500, 32'd10, 32'd20, 32'h0);
      step();
      check_all("stall_release", 32'h1E, 32'h504, 1'b0, 32'h500, enc(0, 3'b000, 7'b0110011), 32'd20);

      // A pending taken flag survives a stall; flush still wins over stall.
      drive(enc(0, 3'b000, 7'b1101111), 32'h600, 32'h0, 32'h0, 32'h100);
      step();
      check_all("jal_pend", 32'h604, 32'h700, 1'b1, 32'h600, enc(0, 3'b000, 7'b1101111), 32'h0);
      bus.stall = 1'b1;
      drive(enc(0, 3'b001, 7'b1100011), 32'h700, 32'd1, 32'd1, 32'h8);
      repeat (2) step();
      check_all("stall_taken", 32'h604, 32'h700, 1'b1, 32'h600, enc(0, 3'b000, 7'b1101111), 32'h0);
      bus.flush = 1'b1;
      drive(enc(0, 3'b000, 7'b1101111), 32'h800, 32'h0, 32'h3, 32'h10);
      step();
      check_all("flush_over_stall", 32'h0, 32'h0, 1'b0, 32'h800, NOP_W, 32'h0);
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      // Back-to-back taken branches: the second is squashed by the flush the first raises.
      drive(enc(0, 3'b000, 7'b1100011), 32'h900, 32'd7, 32'd7, 32'h40);
      step();
      check_all("b2b_first", 32'h0, 32'h940, 1'b1, 32'h900, enc(0, 3'b000, 7'b1100011), 32'd7);
      bus.flush = bus.ex_is_branch_taken;
      drive(enc(0, 3'b000, 7'b1100011), 32'h940, 32'd7, 32'd7, 32'h40);
      step();
      check_all("b2b_second", 32'h0, 32'h0, 1'b0, 32'h940, NOP_W, 32'h0);
      bus.flush = 1'b0;

      // Asynchronous reset mid-cycle, then release and capture on the next edge.
      drive(enc(0, 3'b000, 7'b0110011), 32'hB00, 32'd1, 32'd2, 32'h0);
      step();
      check("pre_async.result", bus.ex_aluresult, 32'd3);
      #2 rst = 1'b0;
      #1;
      check_all("async_reset", 32'h0, 32'h0, 1'b0, 32'h0, NOP_W, 32'h0);
      @(negedge clk1);
      rst = 1'b1;
      step();
      check_all("post_reset", 32'd3, 32'hB04, 1'b0, 32'hB00, enc(0, 3'b000, 7'b0110011), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
